// File: rtl/text_overlay_ctrl.sv
// Purpose: draws a fixed line of NUM_CHARS font-ROM glyphs and commits shadow->active text only in vblank.
// Latency: DrawX/DrawY -> font_addr 1 cycle, -> text_on 2 cycles; a commit copy takes NUM_CHARS cycles.
// Backpressure: wr_ready is low during the commit copy; writes offered while it is low are dropped.
module text_overlay_ctrl #(
  parameter int TEXT_X    = 300,
  parameter int TEXT_Y    = 300,
  parameter int NUM_CHARS = 8,
  parameter int IDXW      = $clog2(NUM_CHARS),
  parameter int VBLANK_Y  = 480
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic [9:0]      DrawX,
  input  logic [9:0]      DrawY,
  input  logic            wr_en,
  input  logic [IDXW-1:0] wr_idx,
  input  logic [6:0]      wr_char,
  output logic            wr_ready,
  output logic [10:0]     font_addr,
  input  logic [7:0]      font_data,
  output logic            text_on,
  output logic            commit_done
);

  typedef enum logic [1:0] {IDLE, PENDING, COPY} state_t;

  localparam logic [10:0] X_LO = 11'(TEXT_X);
  localparam logic [10:0] X_HI = 11'(TEXT_X + 8 * NUM_CHARS);
  localparam logic [10:0] Y_LO = 11'(TEXT_Y);
  localparam logic [10:0] Y_HI = 11'(TEXT_Y + 16);

  state_t          state, state_nxt;
  logic [IDXW-1:0] cnt;
  logic            dirty;
  logic [9:0]      prev_y;
  logic [6:0]      shadow [NUM_CHARS];
  logic [6:0]      active [NUM_CHARS];

  logic            vblank_start;
  logic            wr_acc;
  logic            copy_last;

  logic            in_win;
  logic [IDXW+2:0] dx_lo;
  logic [3:0]      dy_lo;
  logic [IDXW-1:0] glyph_idx;
  logic [2:0]      col_d1;
  logic            win_d1;

  // Edge-detect the first line of vertical blank; a held DrawY produces one strobe only.
  assign vblank_start = (DrawY == 10'(VBLANK_Y)) && (prev_y != 10'(VBLANK_Y));
  assign wr_acc       = wr_en && wr_ready;
  assign copy_last    = (state == COPY) && (cnt == IDXW'(NUM_CHARS - 1));

  // Commit FSM next-state and the write-ready output.
  always_comb begin
    state_nxt = state;
    wr_ready  = (state != COPY);
    case (state)
      IDLE:    if (wr_acc) state_nxt = PENDING;
      PENDING: if (vblank_start && dirty) state_nxt = COPY;
      COPY:    if (copy_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Commit FSM state register.
  always_ff @(posedge Clk) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Copy counter, dirty flag, DrawY history and the end-of-commit pulse.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      cnt         <= '0;
      dirty       <= 1'b0;
      prev_y      <= '0;
      commit_done <= 1'b0;
    end else begin
      prev_y      <= DrawY;
      cnt         <= (state == COPY) ? cnt + IDXW'(1) : '0;
      commit_done <= copy_last;
      if (wr_acc)         dirty <= 1'b1;
      else if (copy_last) dirty <= 1'b0;
    end
  end

  // Shadow takes game-logic writes; active is only touched by the vblank copy.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < NUM_CHARS; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
    end else begin
      if (wr_acc)          shadow[wr_idx] <= wr_char;
      if (state == COPY)   active[cnt]    <= shadow[cnt];
    end
  end

  // Only the low offset bits matter: glyph index, column and row inside the glyph.
  assign in_win    = ({1'b0, DrawX} >= X_LO) && ({1'b0, DrawX} < X_HI) &&
                     ({1'b0, DrawY} >= Y_LO) && ({1'b0, DrawY} < Y_HI);
  assign dx_lo     = (IDXW + 3)'(DrawX - 10'(TEXT_X));
  assign dy_lo     = 4'(DrawY - 10'(TEXT_Y));
  assign glyph_idx = dx_lo[IDXW+2:3];

  // Stage 1: form the font ROM address and carry column/window alongside it.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      font_addr <= '0;
      col_d1    <= '0;
      win_d1    <= 1'b0;
    end else begin
      font_addr <= in_win ? {active[glyph_idx], dy_lo} : 11'd0;
      col_d1    <= dx_lo[2:0];
      win_d1    <= in_win;
    end
  end

  // Stage 2: pick the pixel bit from the ROM row, MSB is the leftmost pixel.
  always_ff @(posedge Clk) begin
    if (Reset) text_on <= 1'b0;
    else       text_on <= win_d1 & font_data[3'd7 - col_d1];
  end

endmodule
